// File: rtl/cmip_pkg.sv
// Shared constants for the multi-channel pulse synchroniser:
// event edge modes, arbiter state encoding and width helper.
package cmip_pkg;

   localparam int EDGE_ANY  = 0;
   localparam int EDGE_RISE = 1;
   localparam int EDGE_FALL = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OFFER = 1'b1
   } arb_state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmip_sync_edge_det.sv
// One channel: SYNC_STAGES-deep synchroniser, history flop and
// registered edge strobe filtered by EDGE_MODE.
module cmip_sync_edge_det
   import cmip_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_ANY
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   pulse_q;
   logic                   last;
   logic                   det;

   assign last = sync_q[SYNC_STAGES-1];

   always_comb begin
      det = last ^ hist_q;
      if (EDGE_MODE == EDGE_RISE) det = last & ~hist_q;
      if (EDGE_MODE == EDGE_FALL) det = ~last & hist_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_async};
         hist_q  <= last;
         pulse_q <= det;
      end
   end

   assign o_pulse = pulse_q;

endmodule

// File: rtl/cmip_pulse_sync_mc.sv
// Multi-channel pulse synchroniser with per-channel pending counters
// and a round-robin valid/ready event offer.
module cmip_pulse_sync_mc
   import cmip_pkg::*;
#(
   parameter int CH_NUM      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0,
   parameter int CNT_W       = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [CH_NUM-1:0]         i_async,
   output logic [CH_NUM-1:0]         o_pulse,
   output logic                      o_evt_valid,
   output logic [ch_w(CH_NUM)-1:0]   o_evt_ch,
   input  logic                      i_evt_ready,
   output logic [CH_NUM-1:0]         o_overflow,
   input  logic [CH_NUM-1:0]         i_ovf_clr
);

   localparam int CH_W = ch_w(CH_NUM);
   localparam int PW   = CH_W + 1;

   if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch
      $error("cmip_pulse_sync_mc: CH_NUM must be 1..32");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("cmip_pulse_sync_mc: SYNC_STAGES must be >= 2");
   end
   if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge
      $error("cmip_pulse_sync_mc: EDGE_MODE must be 0..2");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("cmip_pulse_sync_mc: CNT_W must be >= 1");
   end

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   last_q, last_d;
   logic [CH_W-1:0]   winner;
   logic [PW-1:0]     idx;
   logic [CH_NUM-1:0] req;
   logic              hs;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic             ovf_q;
      logic             inc;
      logic             dec;
      logic             full;

      cmip_sync_edge_det #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_MODE   (EDGE_MODE)
      ) u_sync (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_async (i_async[c]),
         .o_pulse (o_pulse[c])
      );

      assign inc  = o_pulse[c];
      assign dec  = hs && (ch_q == CH_W'(c));
      assign full = &cnt_q;

      // A strobe in flight counts as pending so the offer follows it directly.
      assign req[c] = inc | (cnt_q != '0);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (inc && !dec && !full) cnt_q <= cnt_q + 1'b1;
            else if (dec && !inc)     cnt_q <= cnt_q - 1'b1;
            ovf_q <= (inc && !dec && full) | (ovf_q & ~i_ovf_clr[c]);
         end
      end

      assign o_overflow[c] = ovf_q;
   end

   // Descending scan so the channel nearest after last_q wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = CH_NUM; i >= 1; i--) begin
         idx = {1'b0, last_q} + PW'(i);
         if (idx >= PW'(CH_NUM)) idx = idx - PW'(CH_NUM);
         if (req[idx[CH_W-1:0]]) winner = idx[CH_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      last_d  = last_q;
      hs      = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               state_d = ARB_OFFER;
               ch_d    = winner;
            end
         end
         ARB_OFFER: begin
            if (i_evt_ready) begin
               hs      = 1'b1;
               last_d  = ch_q;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ARB_IDLE;
         ch_q    <= '0;
         last_q  <= CH_W'(CH_NUM - 1);
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
      end
   end

   assign o_evt_valid = (state_q == ARB_OFFER);
   assign o_evt_ch    = ch_q;

endmodule

// File: tb/tb_cmip_pulse_sync_mc.sv
// Directed bench for cmip_pulse_sync_mc: latency, round-robin,
// backpressure, overflow, edge modes and reset mid-offer.
module tb_cmip_pulse_sync_mc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] async_v = '0;
   logic [7:0] ovf_clr = '0;
   logic       ready = 1'b0;

   logic [7:0] pulse, ovf;
   logic       valid;
   logic [2:0] ch;
   logic [7:0] r_pulse, r_ovf, f_pulse, f_ovf;
   logic       r_valid, f_valid;
   logic [2:0] r_ch, f_ch;

   int n_run = 0;
   int n_fail = 0;
   int grants;
   int pa_any, pa_rise, pa_fall, pb_any, pb_rise, pb_fall;

   always #5 clk = ~clk;

   cmip_pulse_sync_mc #(
      .CH_NUM(8), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(2)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_async(async_v),
      .o_pulse(pulse), .o_evt_valid(valid), .o_evt_ch(ch),
      .i_evt_ready(ready), .o_overflow(ovf), .i_ovf_clr(ovf_clr)
   );

   cmip_pulse_sync_mc #(
      .CH_NUM(8), .SYNC_STAGES(2), .EDGE_MODE(1), .CNT_W(4)
   ) dut_rise (
      .i_clk(clk), .i_rst_n(rst_n), .i_async(async_v),
      .o_pulse(r_pulse), .o_evt_valid(r_valid), .o_evt_ch(r_ch),
      .i_evt_ready(1'b1), .o_overflow(r_ovf), .i_ovf_clr(8'h00)
   );

   cmip_pulse_sync_mc #(
      .CH_NUM(8), .SYNC_STAGES(2), .EDGE_MODE(2), .CNT_W(4)
   ) dut_fall (
      .i_clk(clk), .i_rst_n(rst_n), .i_async(async_v),
      .o_pulse(f_pulse), .o_evt_valid(f_valid), .o_evt_ch(f_ch),
      .i_evt_ready(1'b1), .o_overflow(f_ovf), .i_ovf_clr(8'h00)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      async_v = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #2;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pulse", 32'(pulse), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_ch", 32'(ch), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // single event on ch3
      ready = 1'b1;
      async_v[3] = 1'b1;
      step();
      step();
      chk("c3_early", 32'(pulse), 32'h00);
      step();
      chk("c3_pulse", 32'(pulse), 32'h08);
      chk("c3_nvalid", 32'(valid), 32'd0);
      step();
      chk("c3_pulse_off", 32'(pulse), 32'h00);
      chk("c3_valid", 32'(valid), 32'd1);
      chk("c3_ch", 32'(ch), 32'd3);
      step();
      chk("c3_done", 32'(valid), 32'd0);
      step();
      chk("c3_empty", 32'(valid), 32'd0);

      // round robin from pointer 7
      do_reset();
      async_v[0] = 1'b1;
      async_v[2] = 1'b1;
      async_v[5] = 1'b1;
      repeat (3) step();
      chk("rr_pulse", 32'(pulse), 32'h25);
      step();
      chk("rr_v0", 32'(valid), 32'd1);
      chk("rr_ch0", 32'(ch), 32'd0);
      step();
      chk("rr_gap0", 32'(valid), 32'd0);
      step();
      chk("rr_v2", 32'(valid), 32'd1);
      chk("rr_ch2", 32'(ch), 32'd2);
      step();
      chk("rr_gap2", 32'(valid), 32'd0);
      step();
      chk("rr_v5", 32'(valid), 32'd1);
      chk("rr_ch5", 32'(ch), 32'd5);
      step();
      chk("rr_gap5", 32'(valid), 32'd0);
      step();
      chk("rr_empty", 32'(valid), 32'd0);

      // backpressure on ch1, then ch2 before ch0
      ready = 1'b0;
      async_v[1] = 1'b1;
      repeat (4) step();
      chk("bp_v", 32'(valid), 32'd1);
      chk("bp_ch", 32'(ch), 32'd1);
      async_v[0] = 1'b0;
      async_v[2] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_hold_v", 32'(valid), 32'd1);
         chk("bp_hold_ch", 32'(ch), 32'd1);
      end
      ready = 1'b1;
      step();
      chk("bp_rel", 32'(valid), 32'd0);
      step();
      chk("bp_v2", 32'(valid), 32'd1);
      chk("bp_ch2", 32'(ch), 32'd2);
      step();
      chk("bp_gap", 32'(valid), 32'd0);
      step();
      chk("bp_v0", 32'(valid), 32'd1);
      chk("bp_ch0", 32'(ch), 32'd0);
      step();
      chk("bp_gap0", 32'(valid), 32'd0);
      step();
      chk("bp_empty", 32'(valid), 32'd0);

      // overflow on ch7 with CNT_W=2
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         async_v[7] = ~async_v[7];
         step();
         step();
      end
      chk("ov_not_yet", 32'(ovf), 32'h00);
      step();
      step();
      chk("ov_set", 32'(ovf), 32'h80);
      chk("ov_valid", 32'(valid), 32'd1);
      chk("ov_ch", 32'(ch), 32'd7);
      ready = 1'b1;
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         if (valid && ch == 3'd7) grants++;
         step();
      end
      chk("ov_grants", 32'(grants), 32'd3);
      chk("ov_sticky", 32'(ovf), 32'h80);
      ovf_clr = 8'h80;
      step();
      ovf_clr = 8'h00;
      chk("ov_clr", 32'(ovf), 32'h00);

      // edge modes on ch4: rise then fall
      pa_any = 0; pa_rise = 0; pa_fall = 0;
      pb_any = 0; pb_rise = 0; pb_fall = 0;
      async_v[4] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         pa_any  += int'(pulse[4]);
         pa_rise += int'(r_pulse[4]);
         pa_fall += int'(f_pulse[4]);
      end
      async_v[4] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         pb_any  += int'(pulse[4]);
         pb_rise += int'(r_pulse[4]);
         pb_fall += int'(f_pulse[4]);
      end
      chk("em_any_r", 32'(pa_any), 32'd1);
      chk("em_any_f", 32'(pb_any), 32'd1);
      chk("em_rise_r", 32'(pa_rise), 32'd1);
      chk("em_rise_f", 32'(pb_rise), 32'd0);
      chk("em_fall_r", 32'(pa_fall), 32'd0);
      chk("em_fall_f", 32'(pb_fall), 32'd1);

      // reset while offering ch6
      ready = 1'b0;
      async_v[6] = 1'b1;
      repeat (4) step();
      chk("rm_valid", 32'(valid), 32'd1);
      chk("rm_ch", 32'(ch), 32'd6);
      #2;
      rst_n = 1'b0;
      async_v = '0;
      #1;
      chk("rm_async_v", 32'(valid), 32'd0);
      chk("rm_async_ch", 32'(ch), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rm_post_v", 32'(valid), 32'd0);
         chk("rm_post_p", 32'(pulse), 32'h00);
      end
      chk("rm_ovf", 32'(ovf), 32'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/cmip_pulse_sync_mc.md
CMIP_PULSE_SYNC_MC -- requirements
Module: cmip_pulse_sync_mc

Interface
REQ-001 SHALL have parameter CH_NUM, 8, number of channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, 2, synchroniser flop depth (>=2).
REQ-003 SHALL have parameter EDGE_MODE, 0, event definition: 0 = any edge (toggle), 1 = rising, 2 = falling.
REQ-004 SHALL have parameter CNT_W, 4, width of each per-channel pending counter (>=1).
REQ-005 SHALL have port i_clk  input  1  sole clock.
REQ-006 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_async  input  CH_NUM  asynchronous level/toggle lines, one per channel.
REQ-008 SHALL have port o_pulse  output  CH_NUM  one-cycle event strobe per channel.
REQ-009 SHALL have port o_evt_valid  output  1  event offer valid.
REQ-010 SHALL have port o_evt_ch  output  max(1,clog2(CH_NUM))  channel index of offered event.
REQ-011 SHALL have port i_evt_ready  input  1  consumer accepts offered event.
REQ-012 SHALL have port o_overflow  output  CH_NUM  sticky per-channel lost-event flag.
REQ-013 SHALL have port i_ovf_clr  input  CH_NUM  per-channel overflow clear strobe.

Function
REQ-014 Each channel SHALL pass i_async through SYNC_STAGES flops plus one history flop, with edge detection between the last stage and the history flop.
REQ-015 A level change stable before edge k SHALL give o_pulse high for exactly the one cycle after edge k+SYNC_STAGES, with o_pulse registered.
REQ-016 Only edges matching EDGE_MODE SHALL produce o_pulse; in mode 0 each toggle SHALL produce one pulse.
REQ-017 Each channel SHALL hold a pending counter: +1 on o_pulse, -1 on a handshake for that channel, unchanged when both occur in the same cycle.
REQ-018 A pending counter at 2^CNT_W-1 SHALL saturate on a further event without handshake, drop that event, and set o_overflow for that channel.
REQ-019 o_overflow SHALL clear on the matching i_ovf_clr bit; simultaneous set and clear SHALL leave the bit set.
REQ-020 The arbiter FSM SHALL have states IDLE and OFFER.
REQ-021 In IDLE, if any counter is nonzero, the FSM SHALL register the round-robin winner (search starts at last granted channel + 1, wraps at CH_NUM-1 to 0) into o_evt_ch, assert o_evt_valid, and move to OFFER.
REQ-022 In OFFER, o_evt_valid and o_evt_ch SHALL be held stable until i_evt_ready.
REQ-023 A handshake (o_evt_valid and i_evt_ready) SHALL decrement the counter, update the last-granted pointer, deassert o_evt_valid, and return the FSM to IDLE.
REQ-024 Throughput SHALL be one event per two cycles; i_evt_ready while o_evt_valid is low SHALL be ignored.
REQ-025 Pending counters SHALL be read in IDLE after any same-edge decrement has been applied; no channel SHALL be offered with count zero.

Reset
REQ-026 Assertion of i_rst_n low SHALL immediately clear all sync/history flops, counters, o_pulse, o_overflow, o_evt_valid, and o_evt_ch, set the last-granted pointer to CH_NUM-1, and put the FSM in IDLE.
REQ-027 Reset mid-offer SHALL discard all pending events, and no o_pulse SHALL be generated by the first post-reset samples when i_async is low.

Structure
REQ-028 The EDGE_MODE constants and the FSM state encoding SHALL live in shared package cmip_pkg.
REQ-029 The per-channel synchroniser and edge detector SHALL be sub-module cmip_sync_edge_det, instantiated CH_NUM times via generate.
REQ-030 Illegal parameters (SYNC_STAGES<2, CH_NUM outside 1..32, EDGE_MODE>2) SHALL stop elaboration.

Verification
REQ-031 Single edge: ch3 toggles 0->1, SYNC_STAGES=2, i_evt_ready=1 -> o_pulse[3] high one cycle at edge+2, o_evt_valid with o_evt_ch=3 one cycle later, counter returns to 0.
REQ-032 Round-robin: ch0, ch2, ch5 events together, i_evt_ready=1 -> grants in order 0, 2, 5 at 2-cycle spacing, and grants ch2 before ch0 when the last grant was ch1.
REQ-033 Backpressure: i_evt_ready=0 for 20 cycles with offer on ch1 -> o_evt_valid/o_evt_ch=1 stable throughout; a new ch0 event does not preempt.
REQ-034 Overflow: CNT_W=2, 4 toggles on ch7, no ready -> count saturates at 3, o_overflow[7]=1, exactly 3 grants delivered after ready; i_ovf_clr[7] clears the flag.
REQ-035 Edge modes: EDGE_MODE=1 with 0->1->0 input -> one pulse; EDGE_MODE=2 -> one pulse on the fall; EDGE_MODE=0 -> two pulses.
REQ-036 Reset mid-offer: i_rst_n low during OFFER -> o_evt_valid drops asynchronously and all counters read 0 after release.
